// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants, state encoding and digit-validity helper for the serial BCD adder.
package bcd_serial_adder_ctrl_pkg;
  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic bcd_digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction
endpackage

// File: rtl/decimal_adder.sv
// Single-digit BCD adder stage: binary add with carry, then +6 decimal correction.
module decimal_adder
  import bcd_serial_adder_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);
  logic [DIGIT_W:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    cout = raw[DIGIT_W] || (raw[DIGIT_W-1:0] > BCD_MAX);
    s    = cout ? raw[DIGIT_W-1:0] + BCD_CORR : raw[DIGIT_W-1:0];
  end
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: walks one decimal_adder over DIGITS digits, LSD first,
// rippling the decimal carry through a register.
module bcd_serial_adder_ctrl
  import bcd_serial_adder_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      invalid
);
  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state, state_nxt;
  logic [W-1:0]       a_sr, b_sr, sum_r;
  logic [IDX_W-1:0]   idx;
  logic               carry, cout_r, inv_r;
  logic [DIGIT_W-1:0] dig_s;
  logic               dig_c, last, any_bad;

  decimal_adder u_dig (
    .a    (a_sr[DIGIT_W-1:0]),
    .b    (b_sr[DIGIT_W-1:0]),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_c)
  );

  assign last = (idx == IDX_W'(DIGITS - 1));

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      any_bad = any_bad | bcd_digit_invalid(a[i*DIGIT_W +: DIGIT_W])
                        | bcd_digit_invalid(b[i*DIGIT_W +: DIGIT_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ADD;
      S_ADD:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result digits enter from the top so that after DIGITS shifts digit 0 sits in [3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      inv_r  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      a_sr  <= a;
      b_sr  <= b;
      sum_r <= '0;
      idx   <= '0;
      carry <= cin;
      inv_r <= any_bad;
    end else if (state == S_ADD) begin
      a_sr  <= a_sr >> DIGIT_W;
      b_sr  <= b_sr >> DIGIT_W;
      sum_r <= (sum_r >> DIGIT_W) | (W'(dig_s) << (W - DIGIT_W));
      carry <= dig_c;
      idx   <= idx + IDX_W'(1);
      if (last) cout_r <= dig_c;
    end
  end

  assign busy    = (state == S_ADD);
  assign done    = (state == S_DONE);
  assign sum     = sum_r;
  assign cout    = cout_r;
  assign invalid = inv_r;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench: directed cases plus random operands against a decimal-integer model.
module tb_bcd_serial_adder_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk, rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, invalid;
  logic [W-1:0] sum;
  int           n_cmp, n_err;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: treat operands as decimal integers and add them.
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc);
    longint       tot, lim;
    logic         bad;
    int           cyc, nbusy;
    logic [W-1:0] held;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    tot = bcd2int(ta) + bcd2int(tb_v) + longint'(tc);
    bad = has_bad(ta) | has_bad(tb_v);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; nbusy = 0;
    while (!done && cyc < 50) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".done_seen"}, 32'(done), 32'd1);
    chk({tag, ".latency"}, 32'(cyc), 32'(DIGITS));
    chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(DIGITS));
    chk({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, ".invalid"}, 32'(invalid), 32'(bad));
    if (!bad) begin
      chk({tag, ".sum"}, 32'(sum), 32'(int2bcd(tot % lim)));
      chk({tag, ".cout"}, 32'(cout), 32'(tot >= lim));
    end
    held = sum;
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".sum_held"}, 32'(sum), 32'(held));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("reset_outs", {27'd0, busy, done, cout, invalid, 1'b0}, 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("basic", 16'h1234, 16'h5678, 1'b0);
    run_op("carry_all", 16'h9999, 16'h0001, 1'b0);
    run_op("cin_chain", 16'h0999, 16'h0000, 1'b1);
    run_op("max", 16'h9999, 16'h9999, 1'b1);

    // start pulses during ADD and DONE must be ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ign.done", 32'(done), 32'd1);
    chk("ign.sum", 32'(sum), 32'h6912);
    a = 16'h4444; b = 16'h4444; cin = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ign.no_restart", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("ign.still_idle", {30'd0, busy, done}, 32'd0);
    chk("ign.sum_kept", 32'(sum), 32'h6912);

    // asynchronous reset in the third ADD cycle
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.outs", {28'd0, busy, done, cout, invalid}, 32'd0);
    chk("arst.sum", 32'(sum), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("post_rst", 16'h0005, 16'h0005, 1'b0);
    chk("post_rst.val", 32'(sum), 32'h0010);

    run_op("bad_digit", 16'h12A4, 16'h0001, 1'b0);
    run_op("clean_again", 16'h0001, 16'h0001, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      for (int i = 0; i < DIGITS; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) begin
        int p = $urandom_range(0, DIGITS - 1);
        ra[p*4 +: 4] = 4'($urandom_range(10, 15));
      end
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
